clken_gen: RTL and testbench

Parametrised multi-channel clock-enable generator driven from the 25 MHz master clock. Each channel produces a single-cycle `clken` strobe, either by integer division or by a fractional phase accumulator (NCO). Divisors and modes are runtime-writable, so CPU, SID and peripheral rates can be retuned without resynthesis. Per-channel halt/step gives debug single-stepping, and a global sync aligns all channel phases.

---
 rtl/clken_pkg.sv | 14 +
 rtl/clken_chan.sv | 67 ++++++
 rtl/clken_gen.sv | 52 +++++
 tb/tb_clken_gen.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clken_pkg.sv
// Shared types and rate constants for the clock-enable generator.
package clken_pkg;

  // Channel operating mode: integer divider or fractional phase accumulator.
  typedef enum logic {MODE_INT, MODE_NCO} clken_mode_t;

  // Integer-mode load values (N-1) for 1 MHz from 25 MHz.
  localparam int DIV_CPU_1M = 24;
  localparam int DIV_SID_1M = 24;

  // NCO increment for 1.0227 MHz at DIV_W=16: 2681/65536 * 25 MHz.
  localparam int INC_1M0227 = 2681;

endpackage

// File: rtl/clken_chan.sv
// One clock-enable channel: config registers, counter/accumulator and the
// write > sync > halt > count priority chain.
module clken_chan
  import clken_pkg::*;
#(
  parameter int               DIV_W    = 16,
  parameter logic [DIV_W-1:0] RST_VAL  = '0,
  parameter clken_mode_t      RST_MODE = MODE_INT
) (
  input  logic             clk25,
  input  logic             rst_n,
  input  logic             i_wr_hit,
  input  logic             i_wr_mode,
  input  logic [DIV_W-1:0] i_wr_val,
  input  logic             i_sync_clr,
  input  logic             i_halt,
  input  logic             i_step,
  output logic             o_clken,
  output logic [DIV_W-1:0] o_val,
  output logic             o_mode
);

  logic [DIV_W-1:0] r_val;
  clken_mode_t      r_mode;
  logic [DIV_W-1:0] r_cnt;
  logic             r_clken;

  // Accumulator sum one bit wider so the top bit is the NCO carry.
  logic [DIV_W:0]   w_sum;
  logic [DIV_W-1:0] w_cnt_inc;

  assign w_sum     = {1'b0, r_cnt} + {1'b0, r_val};
  assign w_cnt_inc = r_cnt + DIV_W'(1);

  // Config load, phase clear, debug halt/step and normal counting, in priority order.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_val   <= RST_VAL;
      r_mode  <= RST_MODE;
      r_cnt   <= '0;
      r_clken <= 1'b0;
    end else if (i_wr_hit) begin
      r_val   <= i_wr_val;
      r_mode  <= clken_mode_t'(i_wr_mode);
      r_cnt   <= '0;
      r_clken <= 1'b0;
    end else if (i_sync_clr) begin
      r_cnt   <= '0;
      r_clken <= 1'b0;
    end else if (i_halt) begin
      // Counter frozen; each step cycle yields exactly one pulse.
      r_clken <= i_step;
    end else if (r_mode == MODE_NCO) begin
      r_cnt   <= w_sum[DIV_W-1:0];
      r_clken <= w_sum[DIV_W];
    end else begin
      // Pulse on count zero; counter wraps at val (or naturally if above it).
      r_clken <= (r_cnt == '0);
      r_cnt   <= (r_cnt == r_val) ? '0 : w_cnt_inc;
    end
  end

  assign o_clken = r_clken;
  assign o_val   = r_val;
  assign o_mode  = (r_mode == MODE_NCO);

endmodule

// File: rtl/clken_gen.sv
// Multi-channel clock-enable generator: per-channel instances, write decode
// and readback packing.
module clken_gen
  import clken_pkg::*;
#(
  parameter int                      NUM_CH     = 2,
  parameter int                      DIV_W      = 16,
  parameter logic [NUM_CH*DIV_W-1:0] RESET_VAL  = {16'd24, 16'd6},
  parameter logic [NUM_CH-1:0]       RESET_MODE = 2'b00,
  localparam int                     CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk25,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [CH_W-1:0]         wr_ch,
  input  logic                    wr_mode,
  input  logic [DIV_W-1:0]        wr_val,
  input  logic                    sync_clr,
  input  logic [NUM_CH-1:0]       halt,
  input  logic [NUM_CH-1:0]       step,
  output logic [NUM_CH-1:0]       clken,
  output logic [NUM_CH*DIV_W-1:0] cfg_val,
  output logic [NUM_CH-1:0]       cfg_mode
);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      // Out-of-range channel numbers match no instance, so such writes are dropped.
      logic w_wr_hit;
      assign w_wr_hit = wr_en && (int'(wr_ch) == gi);

      clken_chan #(
        .DIV_W    (DIV_W),
        .RST_VAL  (RESET_VAL[gi*DIV_W +: DIV_W]),
        .RST_MODE (clken_mode_t'(RESET_MODE[gi]))
      ) u_chan (
        .clk25      (clk25),
        .rst_n      (rst_n),
        .i_wr_hit   (w_wr_hit),
        .i_wr_mode  (wr_mode),
        .i_wr_val   (wr_val),
        .i_sync_clr (sync_clr),
        .i_halt     (halt[gi]),
        .i_step     (step[gi]),
        .o_clken    (clken[gi]),
        .o_val      (cfg_val[gi*DIV_W +: DIV_W]),
        .o_mode     (cfg_mode[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clken_gen.sv
// Self-checking bench for clken_gen with three channels so that an
// out-of-range write channel can be exercised.
module tb_clken_gen;

  localparam int          NCH = 3;
  localparam int          DW  = 16;
  localparam logic [47:0] RV  = {16'd100, 16'd24, 16'd6};
  localparam logic [2:0]  RM  = 3'b000;

  logic          clk25;
  logic          rst_n;
  logic          wr_en;
  logic [1:0]    wr_ch;
  logic          wr_mode;
  logic [15:0]   wr_val;
  logic          sync_clr;
  logic [2:0]    halt;
  logic [2:0]    step;
  logic [2:0]    clken;
  logic [47:0]   cfg_val;
  logic [2:0]    cfg_mode;

  int checks   = 0;
  int failures = 0;

  // Reference model: per channel, number of advancing edges since last clear.
  longint m_adv  [NCH];
  longint m_val  [NCH];
  bit     m_mode [NCH];
  bit     m_clk  [NCH];

  clken_gen #(
    .NUM_CH     (NCH),
    .DIV_W      (DW),
    .RESET_VAL  (RV),
    .RESET_MODE (RM)
  ) dut (
    .clk25    (clk25),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_mode  (wr_mode),
    .wr_val   (wr_val),
    .sync_clr (sync_clr),
    .halt     (halt),
    .step     (step),
    .clken    (clken),
    .cfg_val  (cfg_val),
    .cfg_mode (cfg_mode)
  );

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      m_val[ch]  = longint'(RV[ch*DW +: DW]);
      m_mode[ch] = RM[ch];
      m_adv[ch]  = 0;
      m_clk[ch]  = 1'b0;
    end
  endtask

  // Integer: pulse on edges 1, val+2, 2(val+1)+1 ... after a clear.
  // NCO: pulse whenever adv*val crosses a multiple of 2^DW.
  function automatic bit pulse_at(input longint adv, input longint v, input bit nco);
    if (!nco) return ((adv - 1) % (v + 1)) == 0;
    return ((adv * v) >> DW) != (((adv - 1) * v) >> DW);
  endfunction

  task automatic model_step();
    for (int ch = 0; ch < NCH; ch++) begin
      if (wr_en && int'(wr_ch) == ch) begin
        m_val[ch]  = longint'(wr_val);
        m_mode[ch] = wr_mode;
        m_adv[ch]  = 0;
        m_clk[ch]  = 1'b0;
      end else if (sync_clr) begin
        m_adv[ch]  = 0;
        m_clk[ch]  = 1'b0;
      end else if (halt[ch]) begin
        m_clk[ch]  = step[ch];
      end else begin
        m_adv[ch]  = m_adv[ch] + 1;
        m_clk[ch]  = pulse_at(m_adv[ch], m_val[ch], m_mode[ch]);
      end
    end
  endtask

  task automatic check_outputs();
    logic [2:0]  e_clk;
    logic [47:0] e_val;
    logic [2:0]  e_mode;
    for (int ch = 0; ch < NCH; ch++) begin
      e_clk[ch]            = m_clk[ch];
      e_val[ch*DW +: DW]   = m_val[ch][DW-1:0];
      e_mode[ch]           = m_mode[ch];
    end
    checks++;
    assert (clken === e_clk) else begin
      failures++;
      $error("FAIL clken t=%0t got=%b exp=%b", $time, clken, e_clk);
    end
    checks++;
    assert (cfg_val === e_val) else begin
      failures++;
      $error("FAIL cfg_val t=%0t got=%h exp=%h", $time, cfg_val, e_val);
    end
    checks++;
    assert (cfg_mode === e_mode) else begin
      failures++;
      $error("FAIL cfg_mode t=%0t got=%b exp=%b", $time, cfg_mode, e_mode);
    end
  endtask

  task automatic cycle(input bit chk);
    @(posedge clk25);
    model_step();
    #1;
    if (chk) check_outputs();
  endtask

  task automatic write_cfg(input int ch, input bit mode, input int val);
    wr_en   = 1'b1;
    wr_ch   = 2'(ch);
    wr_mode = mode;
    wr_val  = 16'(val);
    cycle(1);
    wr_en   = 1'b0;
  endtask

  initial begin
    int  cnt0;
    int  cnt1;
    bit  found;

    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_ch    = '0;
    wr_mode  = 1'b0;
    wr_val   = '0;
    sync_clr = 1'b0;
    halt     = '0;
    step     = '0;
    model_reset();

    // Reset state.
    @(posedge clk25);
    #1;
    checks++;
    assert (clken === 3'b000) else begin
      failures++; $error("FAIL reset_clken got=%b exp=%b", clken, 3'b000);
    end
    checks++;
    assert (cfg_val === 48'h0064_0018_0006) else begin
      failures++; $error("FAIL reset_cfg_val got=%h exp=%h", cfg_val, 48'h0064_0018_0006);
    end
    checks++;
    assert (cfg_mode === 3'b000) else begin
      failures++; $error("FAIL reset_cfg_mode got=%b exp=%b", cfg_mode, 3'b000);
    end
    @(negedge clk25);
    rst_n = 1'b1;

    // Default rates: ch0 every 7, ch1 every 25, first pulses together.
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 50; i++) begin
      cycle(1);
      cnt0 += int'(clken[0]);
      cnt1 += int'(clken[1]);
    end
    checks++;
    assert (cnt0 == 8) else begin
      failures++; $error("FAIL default_ch0_pulses got=%0d exp=%0d", cnt0, 8);
    end
    checks++;
    assert (cnt1 == 2) else begin
      failures++; $error("FAIL default_ch1_pulses got=%0d exp=%0d", cnt1, 2);
    end

    // Runtime write to ch0 mid-count: divide by 3.
    cycle(1);
    cycle(1);
    write_cfg(0, 1'b0, 2);
    checks++;
    assert (clken[0] === 1'b0) else begin
      failures++; $error("FAIL write_clears_clken got=%b exp=%b", clken[0], 1'b0);
    end
    for (int i = 0; i < 12; i++) cycle(1);

    // NCO quarter rate on ch1.
    write_cfg(1, 1'b1, 16384);
    cnt1 = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1);
      cnt1 += int'(clken[1]);
    end
    checks++;
    assert (cnt1 == 4) else begin
      failures++; $error("FAIL nco_quarter_pulses got=%0d exp=%0d", cnt1, 4);
    end

    // Halt ch0 for 20 cycles with three single-cycle steps.
    halt[0] = 1'b1;
    cnt0 = 0;
    for (int i = 0; i < 20; i++) begin
      step[0] = (i == 3 || i == 8 || i == 14);
      cycle(1);
      cnt0 += int'(clken[0]);
    end
    step[0] = 1'b0;
    halt[0] = 1'b0;
    checks++;
    assert (cnt0 == 3) else begin
      failures++; $error("FAIL halt_step_pulses got=%0d exp=%0d", cnt0, 3);
    end
    for (int i = 0; i < 10; i++) cycle(1);

    // sync_clr together with an integer write to ch1.
    sync_clr = 1'b1;
    write_cfg(1, 1'b0, 4);
    sync_clr = 1'b0;
    cycle(1);
    checks++;
    assert (clken[1:0] === 2'b11) else begin
      failures++; $error("FAIL sync_write_align got=%b exp=%b", clken[1:0], 2'b11);
    end
    for (int i = 0; i < 10; i++) cycle(1);

    // Out-of-range channel write.
    write_cfg(3, 1'b1, 999);
    checks++;
    assert (cfg_val === {16'd100, 16'd4, 16'd2}) else begin
      failures++; $error("FAIL bad_ch_write got=%h exp=%h", cfg_val, {16'd100, 16'd4, 16'd2});
    end
    for (int i = 0; i < 5; i++) cycle(1);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      wr_en    = ($urandom_range(0, 15) == 0);
      wr_ch    = 2'($urandom_range(0, 3));
      wr_mode  = 1'($urandom_range(0, 1));
      wr_val   = wr_mode ? 16'($urandom_range(1, 65535)) : 16'($urandom_range(0, 12));
      sync_clr = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 7) == 0) halt = halt ^ 3'($urandom_range(1, 7));
      step     = 3'($urandom_range(0, 7));
      cycle(1);
    end
    wr_en = 1'b0; sync_clr = 1'b0; halt = '0; step = '0;

    // Async reset asserted in the middle of a ch0 pulse.
    write_cfg(0, 1'b0, 3);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1);
      found = clken[0];
    end
    checks++;
    assert (found) else begin
      failures++; $error("FAIL wait_pulse got=%b exp=%b", found, 1'b1);
    end
    #10;
    rst_n = 1'b0;
    #1;
    checks++;
    assert (clken === 3'b000) else begin
      failures++; $error("FAIL async_reset_clken got=%b exp=%b", clken, 3'b000);
    end
    checks++;
    assert (cfg_val === RV) else begin
      failures++; $error("FAIL async_reset_cfg got=%h exp=%h", cfg_val, RV);
    end
    model_reset();
    @(negedge clk25);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) cycle(1);

    // 1.0227 MHz NCO: 2681 pulses per 65536 cycles.
    write_cfg(1, 1'b1, 2681);
    cnt1 = 0;
    for (int i = 0; i < 65536; i++) begin
      cycle(0);
      cnt1 += int'(clken[1]);
    end
    checks++;
    assert (cnt1 == 2681) else begin
      failures++; $error("FAIL nco_2681_pulses got=%0d exp=%0d", cnt1, 2681);
    end
    cycle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
